// File: rtl/ddr3_app_responder.sv
// Behavioural stand-in for the MIG7 DDR3 application interface.
// It queues commands and write bursts, runs them in order against an on-chip array, and returns reads after a fixed latency.
module ddr3_app_responder #(
  parameter int DDRCWidth   = 3,
  parameter int DDRAWidth   = 28,
  parameter int DDRDWidth   = 512,
  parameter int DDRMWidth   = 64,
  parameter int MemAWidth   = 10,
  parameter int CmdDepth    = 8,
  parameter int WDepth      = 8,
  parameter int ReadLatency = 4,
  parameter int InitCycles  = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  output logic                 resetDone_o,
  input  logic [DDRCWidth-1:0] command_i,
  input  logic [DDRAWidth-1:0] address_i,
  input  logic                 commandValid_i,
  output logic                 commandReady_o,
  input  logic [DDRDWidth-1:0] writeData_i,
  input  logic [DDRMWidth-1:0] writeMask_i,
  input  logic                 writeDataValid_i,
  output logic                 writeDataReady_o,
  output logic [DDRDWidth-1:0] readData_o,
  output logic                 readDataValid_o,
  output logic                 errorBadCommand_o
);

  localparam int CAW = $clog2(CmdDepth);
  localparam int WAW = $clog2(WDepth);
  localparam int IW  = $clog2(InitCycles + 1);
  localparam logic [DDRCWidth-1:0] CmdWrite = DDRCWidth'(0);
  localparam logic [DDRCWidth-1:0] CmdRead  = DDRCWidth'(1);

  typedef enum logic {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   initCnt_q, initCnt_d;

  logic [DDRCWidth-1:0] cmdMem [CmdDepth];
  logic [MemAWidth-1:0] idxMem [CmdDepth];
  logic [CAW-1:0]       cmdWr_q, cmdRd_q;
  logic [CAW:0]         cmdCnt_q;

  logic [DDRDWidth-1:0] wdData [WDepth];
  logic [DDRMWidth-1:0] wdMask [WDepth];
  logic [WAW-1:0]       wdWr_q, wdRd_q;
  logic [WAW:0]         wdCnt_q;

  logic [DDRDWidth-1:0] mem [2**MemAWidth];

  logic [ReadLatency-1:0] rdValid_q;
  logic [DDRDWidth-1:0]   rdData_q [ReadLatency];
  logic                   err_q;

  logic                 cmdPush, cmdPop, wdPush, wdPop;
  logic                 memWe, rdLaunch, badSeen;
  logic [DDRCWidth-1:0] headCmd;
  logic [MemAWidth-1:0] headIdx;
  logic                 unusedAddrBits;

  assign unusedAddrBits = ^{address_i[DDRAWidth-1:MemAWidth+3], address_i[2:0]};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StInit;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    if (state_q == StInit) begin
      initCnt_d = initCnt_q + 1'b1;
      if (initCnt_q == IW'(InitCycles - 1)) state_d = StRun;
    end
  end

  assign resetDone_o      = (state_q == StRun);
  // Readies look only at registered counts, so a full queue never accepts on a same-cycle pop.
  assign commandReady_o   = resetDone_o && (cmdCnt_q < (CAW+1)'(CmdDepth));
  assign writeDataReady_o = resetDone_o && (wdCnt_q < (WAW+1)'(WDepth));
  assign cmdPush          = commandValid_i && commandReady_o;
  assign wdPush           = writeDataValid_i && writeDataReady_o;

  assign headCmd = cmdMem[cmdRd_q];
  assign headIdx = idxMem[cmdRd_q];

  always_comb begin
    cmdPop   = 1'b0;
    wdPop    = 1'b0;
    memWe    = 1'b0;
    rdLaunch = 1'b0;
    badSeen  = 1'b0;
    if (!reset_i && cmdCnt_q != '0) begin
      case (headCmd)
        CmdWrite: begin
          if (wdCnt_q != '0) begin
            cmdPop = 1'b1;
            wdPop  = 1'b1;
            memWe  = 1'b1;
          end
        end
        CmdRead: begin
          cmdPop   = 1'b1;
          rdLaunch = 1'b1;
        end
        default: begin
          cmdPop  = 1'b1;
          badSeen = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (cmdPush) begin
      cmdMem[cmdWr_q] <= command_i;
      idxMem[cmdWr_q] <= address_i[MemAWidth+2:3];
    end
    if (wdPush) begin
      wdData[wdWr_q] <= writeData_i;
      wdMask[wdWr_q] <= writeMask_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cmdWr_q  <= '0;
      cmdRd_q  <= '0;
      cmdCnt_q <= '0;
      wdWr_q   <= '0;
      wdRd_q   <= '0;
      wdCnt_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      cmdWr_q  <= cmdWr_q + CAW'(cmdPush);
      cmdRd_q  <= cmdRd_q + CAW'(cmdPop);
      cmdCnt_q <= cmdCnt_q + (CAW+1)'(cmdPush) - (CAW+1)'(cmdPop);
      wdWr_q   <= wdWr_q + WAW'(wdPush);
      wdRd_q   <= wdRd_q + WAW'(wdPop);
      wdCnt_q  <= wdCnt_q + (WAW+1)'(wdPush) - (WAW+1)'(wdPop);
      err_q    <= err_q | badSeen;
    end
  end

  // Array is deliberately not reset so data survives a controller reset.
  always_ff @(posedge clock_i) begin
    if (memWe) begin
      for (int b = 0; b < DDRMWidth; b++) begin
        if (!wdMask[wdRd_q][b]) mem[headIdx][8*b +: 8] <= wdData[wdRd_q][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rdValid_q <= '0;
      for (int i = 0; i < ReadLatency; i++) rdData_q[i] <= '0;
    end else begin
      rdValid_q[0] <= rdLaunch;
      rdData_q[0]  <= rdLaunch ? mem[headIdx] : '0;
      for (int i = 1; i < ReadLatency; i++) begin
        rdValid_q[i] <= rdValid_q[i-1];
        rdData_q[i]  <= rdData_q[i-1];
      end
    end
  end

  assign readDataValid_o   = rdValid_q[ReadLatency-1];
  assign readData_o        = rdData_q[ReadLatency-1];
  assign errorBadCommand_o = err_q;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Bench for ddr3_app_responder: directed scenarios then random traffic, checked against a
// byte-masked array model with in-order write/data pairing and a read scoreboard.
module tb_ddr3_app_responder;

  localparam logic [2:0] CmdW   = 3'b000;
  localparam logic [2:0] CmdR   = 3'b001;
  localparam logic [2:0] CmdBad = 3'b111;

  logic         clock = 1'b0;
  logic         reset;
  logic         resetDone;
  logic [2:0]   command;
  logic [27:0]  address;
  logic         commandValid;
  logic         commandReady;
  logic [511:0] writeData;
  logic [63:0]  writeMask;
  logic         writeDataValid;
  logic         writeDataReady;
  logic [511:0] readData;
  logic         readDataValid;
  logic         errorBadCommand;

  int nChecks = 0;
  int nFails  = 0;
  int cycle   = 0;
  int acceptCycle;
  int rdvCount = 0;
  int lastRdvCycle = -1;
  int rdvCycles [$];

  logic [511:0] model [1024];
  int           pendW [$];
  logic [511:0] pendDData [$];
  logic [63:0]  pendDMask [$];
  logic [511:0] expQ [$];
  int           preIdx [16];

  ddr3_app_responder dut (
    .clock_i          (clock),
    .reset_i          (reset),
    .resetDone_o      (resetDone),
    .command_i        (command),
    .address_i        (address),
    .commandValid_i   (commandValid),
    .commandReady_o   (commandReady),
    .writeData_i      (writeData),
    .writeMask_i      (writeMask),
    .writeDataValid_i (writeDataValid),
    .writeDataReady_o (writeDataReady),
    .readData_o       (readData),
    .readDataValid_o  (readDataValid),
    .errorBadCommand_o(errorBadCommand)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read scoreboard: every valid beat must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (readDataValid) begin
      rdvCount++;
      lastRdvCycle = cycle;
      rdvCycles.push_back(cycle);
      checkOutput("rdv_expected", {511'b0, expQ.size() > 0}, 512'd1);
      if (expQ.size() > 0) checkOutput("read_data", readData, expQ.pop_front());
    end
  end

  function automatic int idxOf(input logic [27:0] a);
    return int'(a >> 3) % 1024;
  endfunction

  function automatic logic [511:0] randWide();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [27:0] aliasAddr(input int idx);
    return 28'(($urandom_range(0, 255) << 13) | (idx << 3) | $urandom_range(0, 7));
  endfunction

  task automatic modelWrite(input int idx, input logic [511:0] d, input logic [63:0] m);
    for (int b = 0; b < 64; b++) if (!m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic applyStimulus(input logic [2:0] cmd, input logic [27:0] addr);
    int budget = 0;
    command = cmd;
    address = addr;
    commandValid = 1'b1;
    while (!commandReady && budget < 200) begin
      step();
      budget++;
    end
    if (!commandReady) begin
      checkOutput("cmd_handshake_timeout", {511'b0, commandReady}, 512'd1);
      commandValid = 1'b0;
      return;
    end
    step();
    acceptCycle = cycle;
    commandValid = 1'b0;
  endtask

  task automatic sendWriteData(input logic [511:0] d, input logic [63:0] m);
    int budget = 0;
    writeData = d;
    writeMask = m;
    writeDataValid = 1'b1;
    while (!writeDataReady && budget < 200) begin
      step();
      budget++;
    end
    if (!writeDataReady) begin
      checkOutput("wdata_handshake_timeout", {511'b0, writeDataReady}, 512'd1);
      writeDataValid = 1'b0;
      return;
    end
    step();
    writeDataValid = 1'b0;
  endtask

  task automatic issueWrite(input logic [27:0] addr);
    applyStimulus(CmdW, addr);
    if (pendDData.size() > 0) modelWrite(idxOf(addr), pendDData.pop_front(), pendDMask.pop_front());
    else pendW.push_back(idxOf(addr));
  endtask

  task automatic issueData(input logic [511:0] d, input logic [63:0] m);
    sendWriteData(d, m);
    if (pendW.size() > 0) modelWrite(pendW.pop_front(), d, m);
    else begin
      pendDData.push_back(d);
      pendDMask.push_back(m);
    end
  endtask

  task automatic issueRead(input logic [27:0] addr);
    expQ.push_back(model[idxOf(addr)]);
    applyStimulus(CmdR, addr);
  endtask

  initial begin
    int base;
    int t;
    reset = 1'b1;
    command = '0;
    address = '0;
    commandValid = 1'b0;
    writeData = '0;
    writeMask = '0;
    writeDataValid = 1'b0;
    repeat (3) step();
    checkOutput("reset_done", {511'b0, resetDone}, 512'd0);
    checkOutput("reset_cmd_ready", {511'b0, commandReady}, 512'd0);
    checkOutput("reset_wd_ready", {511'b0, writeDataReady}, 512'd0);
    checkOutput("reset_rdv", {511'b0, readDataValid}, 512'd0);
    checkOutput("reset_rdata", readData, 512'd0);
    checkOutput("reset_err", {511'b0, errorBadCommand}, 512'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput("init_not_ready", {509'b0, resetDone, commandReady, writeDataReady}, 512'd0);
      step();
    end
    checkOutput("init_done", {511'b0, resetDone}, 512'd1);
    checkOutput("init_cmd_ready", {511'b0, commandReady}, 512'd1);
    checkOutput("init_wd_ready", {511'b0, writeDataReady}, 512'd1);

    $display("[TB] write then read");
    issueWrite(28'h40);
    issueData({64{8'hA5}}, 64'h0);
    repeat (4) step();
    base = rdvCount;
    issueRead(28'h40);
    t = acceptCycle;
    repeat (8) step();
    checkOutput("wr_rd_beats", 512'(rdvCount - base), 512'd1);
    checkOutput("read_latency", 512'(lastRdvCycle - t), 512'd4);

    $display("[TB] masked write");
    issueWrite(28'h40);
    issueData(512'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (3) step();
    issueRead(28'h40);
    repeat (8) step();

    $display("[TB] decoupled write data");
    for (int i = 0; i < 3; i++) begin
      issueWrite(28'(8 * i));
      checkOutput("cmd_ready_no_data", {511'b0, commandReady}, 512'd1);
    end
    for (int i = 1; i <= 3; i++) issueData(512'(i), 64'h0);
    repeat (3) step();
    for (int i = 0; i < 3; i++) issueRead(28'(8 * i));
    issueData(512'h77, 64'h0);
    repeat (3) step();
    issueWrite(28'h18);
    repeat (3) step();
    issueRead(28'h18);
    repeat (10) step();

    $display("[TB] backpressure and aliasing");
    for (int i = 0; i < 8; i++) issueWrite(28'(28'h2000 + 8 * i));
    checkOutput("cmd_full_ready", {511'b0, commandReady}, 512'd0);
    command = CmdR;
    address = 28'h0;
    commandValid = 1'b1;
    step();
    checkOutput("cmd_full_hold", {511'b0, commandReady}, 512'd0);
    step();
    commandValid = 1'b0;
    for (int i = 0; i < 8; i++) issueData(randWide(), (i % 2 == 0) ? 64'h0 : {$urandom, $urandom});
    repeat (4) step();
    checkOutput("cmd_drained_ready", {511'b0, commandReady}, 512'd1);
    for (int i = 0; i < 8; i++) issueRead(28'(8 * i));
    repeat (10) step();

    $display("[TB] illegal command");
    checkOutput("err_before", {511'b0, errorBadCommand}, 512'd0);
    applyStimulus(CmdBad, 28'h40);
    checkOutput("err_pop_cycle", {511'b0, errorBadCommand}, 512'd0);
    step();
    checkOutput("err_set", {511'b0, errorBadCommand}, 512'd1);
    issueRead(28'h40);
    repeat (8) step();
    checkOutput("err_sticky", {511'b0, errorBadCommand}, 512'd1);

    $display("[TB] reset with reads in flight");
    base = rdvCount;
    applyStimulus(CmdR, 28'h0);
    applyStimulus(CmdR, 28'h8);
    step();
    reset = 1'b1;
    repeat (2) step();
    checkOutput("midreset_err", {511'b0, errorBadCommand}, 512'd0);
    checkOutput("midreset_rdv", {511'b0, readDataValid}, 512'd0);
    reset = 1'b0;
    checkOutput("midreset_done", {511'b0, resetDone}, 512'd0);
    repeat (20) step();
    checkOutput("midreset_no_beats", 512'(rdvCount - base), 512'd0);
    checkOutput("reinit_done", {511'b0, resetDone}, 512'd1);
    issueRead(28'h40);
    issueRead(28'h2000);
    repeat (8) step();

    $display("[TB] back-to-back reads");
    rdvCycles.delete();
    for (int i = 0; i < 4; i++) issueRead(28'(8 * i));
    repeat (10) step();
    checkOutput("b2b_beats", 512'(rdvCycles.size()), 512'd4);
    if (rdvCycles.size() == 4) checkOutput("b2b_span", 512'(rdvCycles[3] - rdvCycles[0]), 512'd3);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) begin
      preIdx[i] = (100 + 37 * i) % 1024;
      issueWrite(aliasAddr(preIdx[i]));
      issueData(randWide(), 64'h0);
    end
    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(0, 15);
      case ($urandom_range(0, 2))
        0: begin
          issueWrite(aliasAddr(preIdx[k]));
          issueData(randWide(), {$urandom, $urandom});
        end
        1: begin
          issueData(randWide(), ($urandom_range(0, 1) == 0) ? 64'h0 : {$urandom, $urandom});
          issueWrite(aliasAddr(preIdx[k]));
        end
        default: issueRead(aliasAddr(preIdx[k]));
      endcase
    end
    repeat (30) step();
    checkOutput("scoreboard_drained", 512'(expQ.size()), 512'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/ddr3_app_responder.md
Name: ddr3_app_responder

Overview:
- Single-clock behavioural responder for the MIG7-style DDR3 application interface that the ORAM controller drives: app command/address, write-data with mask, and read-data return.
- Accepts commands and 512b write bursts, executes them in order against an on-chip array, and returns read bursts after a fixed latency.
- Sits in place of the MIG/clock-crossing FIFOs for on-FPGA backend bring-up and for fast simulation of PathORamTop without the DDR3 model.

Parameters:
- DDRCWidth, 3, command width; 3'b000 = write, 3'b001 = read, all other codes illegal.
- DDRAWidth, 28, app address width, in 64b DQ-word units.
- DDRDWidth, 512, data burst width (one BL8 burst per beat).
- DDRMWidth, 64, write-mask width, one bit per byte.
- MemAWidth, 10, log2 of array depth in bursts.
- CmdDepth, 8, command queue depth (power of 2).
- WDepth, 8, write-data queue depth (power of 2).
- ReadLatency, 4, cycles from read execution to ReadDataValid (≥1).
- InitCycles, 16, post-reset calibration emulation time (≥1).

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  synchronous, active-high.
- ResetDone  out  1  emulated init_calib_complete.
- Command  in  DDRCWidth  app_cmd.
- Address  in  DDRAWidth  app_addr.
- CommandValid  in  1  app_en.
- CommandReady  out  1  app_rdy.
- WriteData  in  DDRDWidth  app_wdf_data.
- WriteMask  in  DDRMWidth  app_wdf_mask; 1 = byte NOT written.
- WriteDataValid  in  1  app_wdf_wren/app_wdf_end.
- WriteDataReady  out  1  app_wdf_rdy.
- ReadData  out  DDRDWidth  app_rd_data.
- ReadDataValid  out  1  app_rd_data_valid; no backpressure.
- ErrorBadCommand  out  1  sticky; illegal command seen.

Behaviour:
- Reset, synchronous: queues empty, read pipeline flushed, init counter cleared. Outputs: ResetDone=0, CommandReady=0, WriteDataReady=0, ReadDataValid=0, ReadData=0, ErrorBadCommand=0. Array contents are retained across reset (not cleared).
- Init: an up-counter runs for InitCycles cycles after Reset deasserts, then ResetDone=1 and stays 1 until the next Reset. Both ready outputs are 0 while ResetDone=0.
- Handshakes:
  - CommandReady = ResetDone & (cmd count < CmdDepth).
  - WriteDataReady = ResetDone & (wdata count < WDepth).
  - Both readies depend only on registered counts, so a full queue accepts nothing even if it pops in the same cycle.
  - A transfer happens on Valid & Ready; push and pop in the same cycle leave the count unchanged.
- Index: index = Address[MemAWidth+2:3]. Address[2:0] is ignored (burst aligned). Upper bits alias (wrap-around).
- Executor: handles at most one head command per cycle, strictly in order.
  - Write head: waits until the wdata queue is non-empty, then pops both. Writes bytes where mask=0; bytes where mask=1 keep their old value. Write data may arrive before or after its command, and in any number of cycles.
  - Read head: pops when the queue is non-empty. Array[index] enters the latency pipeline. ReadDataValid pulses exactly ReadLatency cycles after the pop, with ReadData held valid that cycle.
  - Illegal code at head: popped and discarded, no memory effect, ErrorBadCommand set to 1 next cycle.
- Read-after-write ordering: a read behind a write to the same index returns the new data, because the write commits before the read pops. A read never waits on the wdata queue.
- Throughput: back-to-back reads give one ReadDataValid per cycle. Back-to-back writes with data ready give one commit per cycle.
- Reset mid-operation: queued commands, queued write data and in-flight reads are discarded. No ReadDataValid is emitted after Reset is sampled high. Init reruns.
- Queue pointers wrap modulo depth. Counts are log2(depth)+1 bits wide.

Test Plan:
- Init: Reset for 3 cycles, then release → ResetDone=0 and both readies=0 for 16 cycles, then ResetDone=1 and CommandReady=1.
- Write then read: write Address=0x40, data=0xA5…A5, mask=0, then read 0x40 → one ReadDataValid exactly 4 cycles after the read pop, with ReadData=0xA5…A5.
- Masked write: after the previous test, write 0x40 with data=0, mask=0xFFFF_FFFF_FFFF_FFFE → read returns byte0=0x00 and bytes1–63=0xA5.
- Decoupled data: issue 3 write commands (0x0, 0x8, 0x10) with no data; CommandReady stays 1. Then send 3 data beats 1, 2, 3 → reads of 0x0, 0x8, 0x10 return 1, 2, 3. Separately, send write data before its command → same result.
- Backpressure and wrap: hold write data off and push 8 writes → CommandReady=0 on the 9th cycle and the 9th command is not accepted. Then supply data → the queue drains. Address 0x2000 aliases 0x0 (MemAWidth=10).
- Illegal command and reset: Command=3'b111 → ErrorBadCommand=1, no memory change. Issue 2 reads, then assert Reset 2 cycles later → no ReadDataValid appears, ErrorBadCommand=0, and data written earlier is still readable after init.
